// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that feeds a uart_tx transmitter one byte per done handshake
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        i_clock,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [7:0]  i_wr_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count,
    output logic        o_overflow,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_done
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    // A full FIFO drops the write; the pop decision never affects acceptance,
    // so a write arriving while full is dropped even if a pop happens on the same edge.
    assign push = i_wr_en && !o_full;

    // Transmit sequencer: launch one byte from IDLE, strobe for a single cycle in SEND,
    // then park in WAIT_DONE until the transmitter reports completion.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        o_tx_dv    = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                o_tx_dv    = 1'b1;
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sequencer state register; reset abandons any outstanding done wait.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy after this edge: a simultaneous push and pop cancel out.
    always_comb begin
        count_next = o_count;
        case ({push, pop})
            2'b10:   count_next = o_count + COUNT_ONE;
            2'b01:   count_next = o_count - COUNT_ONE;
            default: count_next = o_count;
        endcase
    end

    // Pointers, occupancy and the registered full/empty/overflow flags.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            o_count    <= count_next;
            o_empty    <= (count_next == '0);
            o_full     <= (count_next == FULL_COUNT);
            o_overflow <= i_wr_en && o_full;
        end
    end

    // Byte storage; contents are left as-is by reset since the pointers define validity.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Launched byte is held stable for the transmitter until the next launch.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_byte <= 8'h00;
        end else if (pop) begin
            o_tx_byte <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue-based model
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          r_clock   = 1'b0;
    logic          r_rst_n   = 1'b1;
    logic          r_wr_en   = 1'b0;
    logic [7:0]    r_wr_data = 8'h00;
    logic          r_tx_done = 1'b0;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    logic          w_overflow;
    logic          w_tx_dv;
    logic [7:0]    w_tx_byte;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, whether a launched byte awaits completion,
    // the edge index of the last launch, and the outputs expected after the last edge.
    logic [7:0] m_q[$];
    bit         m_busy   = 1'b0;
    int         m_edge   = 0;
    int         m_launch = 0;
    bit         m_dv     = 1'b0;
    bit         m_ovf    = 1'b0;
    logic [7:0] m_byte   = 8'h00;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clock    (r_clock),
        .i_rst_n    (r_rst_n),
        .i_wr_en    (r_wr_en),
        .i_wr_data  (r_wr_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_overflow (w_overflow),
        .o_tx_dv    (w_tx_dv),
        .o_tx_byte  (w_tx_byte),
        .i_tx_done  (r_tx_done)
    );

    always #5 r_clock = ~r_clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_byte = 8'h00;
    endtask

    task automatic do_reset();
        #1;
        r_rst_n = 1'b0;
        model_reset();
        #10;
        r_rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
    task automatic tick(input bit wr, input logic [7:0] d, input bit done);
        int sz;
        bit do_pop;
        r_wr_en   = wr;
        r_wr_data = d;
        r_tx_done = done;
        @(posedge r_clock);
        sz     = m_q.size();
        do_pop = !m_busy && sz > 0;
        m_ovf  = wr && sz == DEPTH;
        if (m_busy && done && m_edge >= m_launch + 2) m_busy = 1'b0;
        m_dv = do_pop;
        if (do_pop) begin
            m_byte   = m_q.pop_front();
            m_busy   = 1'b1;
            m_launch = m_edge;
        end
        if (wr && sz < DEPTH) m_q.push_back(d);
        m_edge++;
        #1;
        r_wr_en   = 1'b0;
        r_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        r_rst_n = 1'b0;
        model_reset();
        #10;
        checks++; if (w_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", w_count); end
        checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", w_empty); end
        checks++; if (w_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", w_full); end
        checks++; if (w_tx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b exp 0", w_tx_dv); end
        checks++; if (w_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", w_tx_byte); end
        checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", w_overflow); end
        r_rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        do_reset();
        tick(1'b1, 8'hAB, 1'b0);
        checks++; if (w_empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write got %0b exp 0", w_empty); end
        checks++; if (w_tx_dv !== 1'b0) begin errors++; $display("FAIL single_dv_early got %0b exp 0", w_tx_dv); end
        tick(1'b0, 8'h00, 1'b0);
        checks++; if (w_tx_dv !== 1'b1) begin errors++; $display("FAIL single_dv got %0b exp 1", w_tx_dv); end
        checks++; if (w_tx_byte !== 8'hAB) begin errors++; $display("FAIL single_byte got %h exp ab", w_tx_byte); end
        checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %0b exp 1", w_empty); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (w_tx_dv !== 1'b0) begin errors++; $display("FAIL single_dv_width got %0b exp 0", w_tx_dv); end
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h5C, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        checks++; if (w_tx_dv !== 1'b1 || w_tx_byte !== 8'h5C) begin errors++; $display("FAIL single_after_done got dv=%0b byte=%h exp dv=1 byte=5c", w_tx_dv, w_tx_byte); end
    endtask

    task automatic test_burst();
        logic [7:0] got[$];
        int cd = 0;
        int done_cyc = -10;
        int peak = 0;
        bit done_now;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            done_now = (cd == 1);
            if (cd > 0) cd--;
            tick(c < 5, 8'(c + 1), done_now);
            if (done_now) done_cyc = c;
            if (int'(w_count) > peak) peak = int'(w_count);
            if (w_tx_dv) begin
                got.push_back(w_tx_byte);
                if (got.size() > 1) begin
                    checks++; if (c != done_cyc + 1) begin errors++; $display("FAIL burst_gap byte %0d at cycle %0d exp %0d", got.size(), c, done_cyc + 1); end
                end
                cd = 5;
            end
        end
        checks++; if (peak !== 4) begin errors++; $display("FAIL burst_peak got %0d exp 4", peak); end
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL burst_len got %0d exp 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order idx %0d got %h exp %h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 8'(8'h40 + i), 1'b0);
        checks++; if (w_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", w_full); end
        checks++; if (int'(w_count) !== DEPTH) begin errors++; $display("FAIL ovf_count_full got %0d exp %0d", w_count, DEPTH); end
        checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b exp 0", w_overflow); end
        tick(1'b1, 8'hEE, 1'b0);
        checks++; if (w_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %0b exp 1", w_overflow); end
        checks++; if (int'(w_count) !== DEPTH) begin errors++; $display("FAIL ovf_count_kept got %0d exp %0d", w_count, DEPTH); end
        tick(1'b0, 8'h00, 1'b0);
        checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %0b exp 0", w_overflow); end
        checks++; if (w_tx_byte !== 8'h40) begin errors++; $display("FAIL ovf_byte_held got %h exp 40", w_tx_byte); end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        int idx = 0;
        int cd = 0;
        bit done_now;
        bit wr;
        do_reset();
        for (int c = 0; c < 1000 && got.size() < 40; c++) begin
            done_now = (cd == 1);
            if (cd > 0) cd--;
            wr = (idx < 40) && (m_q.size() < DEPTH);
            tick(wr, 8'(idx), done_now);
            if (wr) idx++;
            if (w_overflow) begin
                checks++; errors++; $display("FAIL wrap_overflow got 1 exp 0 at cycle %0d", c);
            end
            if (w_tx_dv) begin
                got.push_back(w_tx_byte);
                cd = 3;
            end
        end
        checks++; if (got.size() !== 40) begin errors++; $display("FAIL wrap_len got %0d exp 40", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL wrap_order idx %0d got %h exp %h", i, got[i], 8'(i)); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        checks++; if (int'(w_count) !== 1) begin errors++; $display("FAIL simul_count got %0d exp 1", w_count); end
        checks++; if (w_tx_dv !== 1'b1 || w_tx_byte !== 8'h11) begin errors++; $display("FAIL simul_pop got dv=%0b byte=%h exp dv=1 byte=11", w_tx_dv, w_tx_byte); end
    endtask

    task automatic test_reset_mid();
        int dv_seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h70 + i), 1'b0);
        checks++; if (int'(w_count) !== 3) begin errors++; $display("FAIL midrst_pre_count got %0d exp 3", w_count); end
        #2;
        r_rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (w_tx_dv !== 1'b0) begin errors++; $display("FAIL midrst_dv got %0b exp 0", w_tx_dv); end
        checks++; if (w_count !== '0) begin errors++; $display("FAIL midrst_count got %0d exp 0", w_count); end
        checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %0b exp 1", w_empty); end
        #10;
        r_rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 8'h00, 1'b1);
            if (w_tx_dv) dv_seen++;
        end
        checks++; if (dv_seen !== 0) begin errors++; $display("FAIL midrst_no_dv got %0d pulses exp 0", dv_seen); end
    endtask

    task automatic test_random();
        int pct [3] = '{20, 60, 95};
        bit prev_dv = 1'b0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 500; c++) begin
                tick($urandom_range(99) < pct[p], 8'($urandom), $urandom_range(99) < 30);
                checks++; if (int'(w_count) !== m_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", w_count, m_q.size()); end
                checks++; if (w_empty !== (m_q.size() == 0)) begin errors++; $display("FAIL rand_empty got %0b exp %0b", w_empty, m_q.size() == 0); end
                checks++; if (w_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full got %0b exp %0b", w_full, m_q.size() == DEPTH); end
                checks++; if (w_overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf got %0b exp %0b", w_overflow, m_ovf); end
                checks++; if (w_tx_dv !== m_dv) begin errors++; $display("FAIL rand_dv got %0b exp %0b", w_tx_dv, m_dv); end
                checks++; if (w_tx_byte !== m_byte) begin errors++; $display("FAIL rand_byte got %h exp %h", w_tx_byte, m_byte); end
                checks++; if (prev_dv && w_tx_dv) begin errors++; $display("FAIL rand_dv_double got 1 exp 0"); end
                prev_dv = w_tx_dv;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
